// File: rtl/chess_pkg.sv
// Shared chess definitions: piece encodings, square/FIFO word geometry and the
// move scheduler state encoding.
`timescale 1ns/1ps
package chess_pkg;

  localparam int SQ_W       = 6;
  localparam int WORD_W     = 48;
  localparam int NSLOT      = 8;
  localparam int SLOT_IDX_W = 3;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_e;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } color_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_SQ,
    ST_WAIT_DONE,
    ST_SCAN,
    ST_READ,
    ST_UNPACK,
    ST_FINISH
  } sched_state_e;

  // Source square held in slot idx of a FIFO word (slot i = bits [6*i+5:6*i]).
  function automatic logic [SQ_W-1:0] slot_of(input logic [WORD_W-1:0]     word,
                                               input logic [SLOT_IDX_W-1:0] idx);
    return word[int'(idx)*SQ_W +: SQ_W];
  endfunction

endpackage

// File: rtl/slot_unpacker.sv
// Holds one captured FIFO word and streams its slots (7 down to 0) as moves,
// silently dropping self-move filler slots.
`timescale 1ns/1ps
module slot_unpacker
  import chess_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word_in,
  input  logic [SQ_W-1:0]   cur_sq,
  input  logic              mv_ready,
  output logic              mv_valid,
  output logic [SQ_W-1:0]   mv_from,
  output logic [SQ_W-1:0]   mv_to,
  output logic              handshake,
  output logic              word_done
);

  logic [WORD_W-1:0]     word_q, word_d;
  logic [SLOT_IDX_W-1:0] idx_q, idx_d;
  logic                  active_q, active_d;
  logic [SQ_W-1:0]       slot;
  logic                  skip;
  logic                  advance;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      word_q   <= word_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

  // A filler slot advances unconditionally; a real move waits for the consumer.
  always_comb begin
    slot      = slot_of(word_q, idx_q);
    skip      = (slot == cur_sq);
    mv_valid  = active_q && !skip;
    handshake = mv_valid && mv_ready;
    advance   = active_q && (skip || mv_ready);
    word_done = advance && (idx_q == '0);
    mv_from   = mv_valid ? slot : '0;
    mv_to     = mv_valid ? cur_sq : '0;

    word_d   = word_q;
    idx_d    = idx_q;
    active_d = active_q;
    if (load) begin
      word_d   = word_in;
      idx_d    = SLOT_IDX_W'(NSLOT - 1);
      active_d = 1'b1;
    end else if (advance) begin
      idx_d = idx_q - 1'b1;
      if (idx_q == '0) begin
        active_d = 1'b0;
      end
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Runs one move-generation pass: resets the square array, waits for it to
// settle, then drains every square FIFO in ascending order into a move stream.
`timescale 1ns/1ps
module move_scheduler
  import chess_pkg::*;
#(
  parameter int NSQ        = 64,
  parameter int RST_CYCLES = 2,
  parameter int SETTLE     = 2,
  parameter int RD_LAT     = 1,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              sq_reset,
  input  logic [NSQ-1:0]    sq_done,
  input  logic [NSQ-1:0]    sq_hold,
  input  logic [NSQ-1:0]    sq_empty,
  output logic [SQ_W-1:0]   sq_sel,
  output logic [NSQ-1:0]    sq_rden,
  input  logic [WORD_W-1:0] sq_fifo_data,
  output logic              mv_valid,
  input  logic              mv_ready,
  output logic [SQ_W-1:0]   mv_from,
  output logic [SQ_W-1:0]   mv_to,
  output logic              list_done,
  output logic [7:0]        move_count,
  output logic              err_timeout
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int SC_W = $clog2(SETTLE + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int RL_W = $clog2(RD_LAT + 2);

  sched_state_e    state_q, state_d;
  logic [SQ_W-1:0] sel_q, sel_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [SC_W-1:0] settle_q, settle_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic [RL_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]      count_q, count_d;
  logic            err_q, err_d;

  logic            load;
  logic            handshake;
  logic            word_done;
  logic            all_settled;

  slot_unpacker u_unpacker (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .word_in   (sq_fifo_data),
    .cur_sq    (sel_q),
    .mv_ready  (mv_ready),
    .mv_valid  (mv_valid),
    .mv_from   (mv_from),
    .mv_to     (mv_to),
    .handshake (handshake),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      rst_cnt_q <= '0;
      settle_q  <= '0;
      tmo_q     <= '0;
      rd_cnt_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rst_cnt_q <= rst_cnt_d;
      settle_q  <= settle_d;
      tmo_q     <= tmo_d;
      rd_cnt_q  <= rd_cnt_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rst_cnt_d   = rst_cnt_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    rd_cnt_d    = rd_cnt_q;
    count_d     = count_q;
    err_d       = err_q;
    sq_reset    = 1'b0;
    sq_rden     = '0;
    list_done   = 1'b0;
    load        = 1'b0;
    all_settled = (&sq_done) && !(|sq_hold);
    busy        = (state_q != ST_IDLE) && (state_q != ST_FINISH);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RST_SQ;
          count_d   = '0;
          err_d     = 1'b0;
          rst_cnt_d = '0;
          sel_d     = '0;
        end
      end
      ST_RST_SQ: begin
        sq_reset = 1'b1;
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
          state_d  = ST_WAIT_DONE;
          settle_d = '0;
          tmo_d    = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      // A settle hit in the same cycle as the timeout wins.
      ST_WAIT_DONE: begin
        settle_d = all_settled ? settle_q + 1'b1 : '0;
        if (all_settled && (settle_q == SC_W'(SETTLE - 1))) begin
          state_d = ST_SCAN;
          sel_d   = '0;
        end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_SCAN: begin
        if (!sq_empty[sel_q]) begin
          state_d  = ST_READ;
          rd_cnt_d = '0;
        end else if (sel_q == SQ_W'(NSQ - 1)) begin
          state_d = ST_FINISH;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      ST_READ: begin
        if (rd_cnt_q == '0) begin
          sq_rden[sel_q] = 1'b1;
        end
        if (rd_cnt_q == RL_W'(RD_LAT)) begin
          load    = 1'b1;
          state_d = ST_UNPACK;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      // Return to the same square so a FIFO with several words drains fully.
      ST_UNPACK: begin
        if (word_done) begin
          state_d = ST_SCAN;
        end
      end
      ST_FINISH: begin
        list_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (handshake && (count_q != 8'hFF)) begin
      count_d = count_q + 1'b1;
    end
  end

  assign sq_sel      = sel_q;
  assign move_count  = count_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: a FIFO model feeds the DUT and the
// expected move stream is derived from the loaded words.
`timescale 1ns/1ps
module tb_move_scheduler;

  localparam int NSQ = 64;

  typedef struct {
    int          sq;
    logic [47:0] w;
  } fifo_ent_t;

  typedef struct {
    logic [5:0] from;
    logic [5:0] to;
  } move_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           busy;
  logic           sq_reset;
  logic [NSQ-1:0] sq_done;
  logic [NSQ-1:0] sq_hold;
  logic [NSQ-1:0] sq_empty;
  logic [5:0]     sq_sel;
  logic [NSQ-1:0] sq_rden;
  logic [47:0]    sq_fifo_data;
  logic           mv_valid;
  logic           mv_ready;
  logic [5:0]     mv_from;
  logic [5:0]     mv_to;
  logic           list_done;
  logic [7:0]     move_count;
  logic           err_timeout;

  fifo_ent_t fifo_q[$];
  move_t     exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc, busy_nr_cycles, rst_cycles, rden0, rden_total, ld_cnt;
  int ld_move_count, ld_err, valid_seen, stall_cycles, moves_seen;
  int sel1_cyc, done_cyc;
  logic       prev_stall;
  logic [5:0] prev_from, prev_to;

  always #5 clk = ~clk;

  move_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .sq_reset     (sq_reset),
    .sq_done      (sq_done),
    .sq_hold      (sq_hold),
    .sq_empty     (sq_empty),
    .sq_sel       (sq_sel),
    .sq_rden      (sq_rden),
    .sq_fifo_data (sq_fifo_data),
    .mv_valid     (mv_valid),
    .mv_ready     (mv_ready),
    .mv_from      (mv_from),
    .mv_to        (mv_to),
    .list_done    (list_done),
    .move_count   (move_count),
    .err_timeout  (err_timeout)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic update_empty();
    sq_empty = '1;
    foreach (fifo_q[k]) sq_empty[fifo_q[k].sq] = 1'b0;
  endtask

  task automatic load_word(input int sq, input logic [47:0] w);
    fifo_ent_t e;
    e.sq = sq;
    e.w  = w;
    fifo_q.push_back(e);
    update_empty();
  endtask

  function automatic logic [47:0] set_slot(input logic [47:0] w, input int k, input logic [5:0] v);
    logic [47:0] r;
    r = w;
    r[k*6 +: 6] = v;
    return r;
  endfunction

  // Expected stream: ascending square, words in FIFO order, slot 7..0, no self-moves.
  task automatic build_expected();
    move_t m;
    logic [5:0] s;
    exp_q.delete();
    for (int sq = 0; sq < NSQ; sq++) begin
      foreach (fifo_q[k]) begin
        if (fifo_q[k].sq == sq) begin
          for (int j = 7; j >= 0; j--) begin
            s = fifo_q[k].w[j*6 +: 6];
            if (s != 6'(sq)) begin
              m.from = s;
              m.to   = 6'(sq);
              exp_q.push_back(m);
            end
          end
        end
      end
    end
  endtask

  task automatic clear_stats();
    busy_nr_cycles = 0; rst_cycles = 0; rden0 = 0; rden_total = 0; ld_cnt = 0;
    ld_move_count = 0; ld_err = 0; valid_seen = 0; stall_cycles = 0; moves_seen = 0;
    sel1_cyc = -1; done_cyc = -1; prev_stall = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic applyStimulus(input int max_cycles);
    int n;
    clear_stats();
    build_expected();
    pulse_start();
    n = 0;
    while (ld_cnt == 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pass_ended", int'(ld_cnt > 0), 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("exp_left", exp_q.size(), 0);
  endtask

  // FIFO model and output monitor, sampled on the falling edge.
  initial begin
    move_t m;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (busy && !sq_reset) busy_nr_cycles++;
        if (sq_reset) rst_cycles++;
        if (sq_rden[0]) rden0++;
        if (|sq_rden) rden_total++;
        if (sq_sel == 6'd1 && sel1_cyc < 0) sel1_cyc = cyc;
        if (list_done) begin
          ld_cnt++;
          ld_move_count = move_count;
          ld_err = err_timeout;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (mv_valid) begin
          valid_seen++;
          if (prev_stall) begin
            checkOutput("hold_from", mv_from, prev_from);
            checkOutput("hold_to", mv_to, prev_to);
          end
          if (mv_ready) begin
            moves_seen++;
            if (exp_q.size() == 0) begin
              checkOutput("extra_move", 1, 0);
            end else begin
              m = exp_q.pop_front();
              checkOutput("mv_from", mv_from, m.from);
              checkOutput("mv_to", mv_to, m.to);
            end
          end else begin
            stall_cycles++;
          end
          prev_stall = !mv_ready;
          prev_from  = mv_from;
          prev_to    = mv_to;
        end else begin
          if (prev_stall) checkOutput("valid_dropped", 0, 1);
          prev_stall = 1'b0;
        end
        if (|sq_rden) begin
          for (int i = 0; i < NSQ; i++) begin
            if (sq_rden[i]) begin
              for (int k = 0; k < fifo_q.size(); k++) begin
                if (fifo_q[k].sq == i) begin
                  sq_fifo_data = fifo_q[k].w;
                  fifo_q.delete(k);
                  break;
                end
              end
            end
          end
          update_empty();
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [47:0] w;
    int n;
    reset = 1'b0; start = 1'b0; mv_ready = 1'b1;
    sq_done = '0; sq_hold = '0; sq_empty = '1; sq_fifo_data = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sq_reset", sq_reset, 0);
    checkOutput("rst_mv_valid", mv_valid, 0);
    checkOutput("rst_rden", int'(|sq_rden), 0);
    checkOutput("rst_list_done", list_done, 0);
    checkOutput("rst_move_count", move_count, 0);
    checkOutput("rst_err", err_timeout, 0);
    checkOutput("rst_sq_sel", sq_sel, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Pass 1: every FIFO empty, done rises a few cycles after start.
    $display("[TB] empty pass");
    fork
      applyStimulus(400);
      begin
        repeat (3) @(posedge clk);
        #1 sq_done = '1;
      end
    join
    checkOutput("p1_rst_cycles", rst_cycles, 2);
    checkOutput("p1_scan_len", done_cyc - sel1_cyc, 63);
    checkOutput("p1_list_done", ld_cnt, 1);
    checkOutput("p1_move_count", ld_move_count, 0);
    checkOutput("p1_valid_seen", valid_seen, 0);
    checkOutput("p1_rden", rden_total, 0);
    checkOutput("p1_err", ld_err, 0);
    checkOutput("p1_busy_after", busy, 0);

    // Pass 2: square 12 with two real slots among self-move filler.
    $display("[TB] filler skip pass");
    w = {8{6'd12}};
    w = set_slot(w, 7, 6'd4);
    w = set_slot(w, 5, 6'd20);
    load_word(12, w);
    applyStimulus(400);
    checkOutput("p2_move_count", ld_move_count, 2);
    checkOutput("p2_moves", moves_seen, 2);

    // Pass 3: two words at square 0, one at square 63.
    $display("[TB] multi-word pass");
    load_word(0, set_slot(48'd0, 3, 6'd9));
    load_word(0, set_slot(48'd0, 6, 6'd17));
    load_word(63, set_slot({8{6'd63}}, 0, 6'd5));
    applyStimulus(400);
    checkOutput("p3_move_count", ld_move_count, 3);
    checkOutput("p3_rden0", rden0, 2);
    checkOutput("p3_rden_total", rden_total, 3);

    // Pass 4: consumer stalls five cycles in the middle of an eight-move word.
    $display("[TB] back-pressure pass");
    w = '0;
    for (int k = 0; k < 8; k++) w = set_slot(w, k, 6'(k + 1));
    load_word(40, w);
    fork
      applyStimulus(600);
      begin
        n = 0;
        while (moves_seen < 3 && n < 600) begin
          @(posedge clk);
          n++;
        end
        #1 mv_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 mv_ready = 1'b1;
      end
    join
    checkOutput("p4_stall_cycles", stall_cycles, 5);
    checkOutput("p4_move_count", ld_move_count, 8);
    checkOutput("p4_moves", moves_seen, 8);

    // Pass 5: one square never reports done.
    $display("[TB] timeout pass");
    sq_done = '1;
    sq_done[30] = 1'b0;
    applyStimulus(1500);
    checkOutput("p5_err", ld_err, 1);
    checkOutput("p5_wait_cycles", busy_nr_cycles, 1023);
    checkOutput("p5_move_count", ld_move_count, 0);
    checkOutput("p5_list_done", ld_cnt, 1);
    sq_done = '1;

    // Pass 6: reset lands while a move is being offered, then a clean pass.
    $display("[TB] abort pass");
    w = '0;
    for (int k = 0; k < 8; k++) w = set_slot(w, k, 6'(k + 10));
    load_word(5, w);
    clear_stats();
    build_expected();
    mv_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!mv_valid && n < 400) begin
      @(posedge clk);
      n++;
    end
    checkOutput("p6_reached_unpack", mv_valid, 1);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("p6_abort_busy", busy, 0);
    checkOutput("p6_abort_valid", mv_valid, 0);
    checkOutput("p6_abort_from_to", {mv_from, mv_to}, 0);
    checkOutput("p6_abort_misc", {sq_reset, list_done, err_timeout, sq_sel}, 0);
    checkOutput("p6_abort_count", move_count, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("p6_no_list_done", ld_cnt, 0);
    fifo_q.delete();
    w = {8{6'd7}};
    w = set_slot(w, 2, 6'd33);
    w = set_slot(w, 1, 6'd34);
    load_word(7, w);
    mv_ready = 1'b1;
    applyStimulus(400);
    checkOutput("p6_move_count", ld_move_count, 2);
    checkOutput("p6_moves", moves_seen, 2);
    checkOutput("p6_err", ld_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Sequences the 64 square units through one move-generation pass.
- Asserts the board-start pulse to the squares, waits until every square reports settled done, then drains each square's move FIFO in ascending square order.
- Unpacks each 48-bit FIFO word into individual (from,to) moves and streams them to the search logic over a valid/ready interface.
- Sits between the square-unit array and the move-list consumer.

Parameters:
NSQ, 64, number of square units; square index = {xpos,ypos}.
RST_CYCLES, 2, cycles sq_reset is held high per pass.
SETTLE, 2, consecutive cycles all sq_done must be high (with sq_hold all low) before draining.
RD_LAT, 1, cycles from sq_rden to valid sq_fifo_data.
TIMEOUT, 1023, WAIT_DONE cycle limit before error.

Ports:
clk  in  1  clock; all state on posedge
reset  in  1  asynchronous, active-low; clears all state
start  in  1  one-cycle request to generate moves for the loaded board
busy  out  1  high from accepting start until list_done
sq_reset  out  1  broadcast board-start to all square units
sq_done  in  NSQ  per-square done
sq_hold  in  NSQ  per-square hold (ORed neighbour hold)
sq_empty  in  NSQ  per-square FIFO empty
sq_sel  out  6  square currently addressed; external mux selects that square's FIFO output
sq_rden  out  NSQ  one-hot FIFO read enable
sq_fifo_data  in  48  selected FIFO word; eight 6-bit source slots
mv_valid  out  1  move available
mv_ready  in  1  consumer accepts move
mv_from  out  6  source square
mv_to  out  6  destination square (= sq_sel at read)
list_done  out  1  one-cycle pulse at end of pass
move_count  out  8  moves emitted this pass, saturating at 255
err_timeout  out  1  sticky until next accepted start

Behaviour:
- Reset (reset=0) values: state IDLE, all outputs 0, counters 0.
- States:
  - IDLE: start=1 -> RST_SQ; clear move_count and err_timeout; busy=1. start while busy is ignored.
  - RST_SQ: sq_reset=1 for RST_CYCLES cycles -> WAIT_DONE.
  - WAIT_DONE: settle counter increments while (&sq_done) && !(|sq_hold), and clears otherwise. Reaching SETTLE -> SCAN with sq_sel=0. Timeout counter reaching TIMEOUT -> err_timeout=1 and FINISH.
  - SCAN: if sq_empty[sq_sel]=0 -> READ. Otherwise, if sq_sel=NSQ-1 -> FINISH, else sq_sel+1 and stay. One square is evaluated per cycle.
  - READ: sq_rden[sq_sel]=1 for exactly one cycle, then wait RD_LAT cycles. Capture sq_fifo_data into a word register and set slot index to 7 -> UNPACK.
  - UNPACK: examines the slot at the current index, using bits [6*i+5:6*i], highest slot first.
    - Slot equal to sq_sel (self-move filler) is skipped, costing one cycle and emitting no move.
    - Otherwise mv_valid=1, mv_from=slot, mv_to=sq_sel. The slot advances only when mv_valid&&mv_ready.
    - mv_from and mv_to are stable while mv_valid=1 and mv_ready=0.
    - After slot 0 -> SCAN with the same sq_sel, so a square holding several words is fully drained.
  - FINISH: list_done=1 for one cycle, busy=0 -> IDLE.
- move_count increments on each handshake and saturates at 255.
- No square is skipped. The emission order is ascending destination, then slot 7..0 within each word.
- Reset asserted mid-pass aborts immediately. No partial list_done is issued.

Decomposition:
- chess_pkg holds:
  - piece encodings (EMPTY..KING, WHITE/BLACK)
  - square index width (6)
  - FIFO word width (48), slot count (8)
  - the scheduler state enum
- Sub-module slot_unpacker owns the word register, slot index, skip logic and valid/ready output. The top level holds the FSM, counters and one-hot rden decode.

Test Plan:
- All FIFOs empty, all done after 3 cycles -> sq_reset high 2 cycles, 64 SCAN cycles, list_done with move_count=0, no mv_valid.
- Square 12 holds a word with slot7=6'd4, slot5=6'd20 and the other slots=6'd12 -> exactly moves (4,12) then (20,12), move_count=2.
- Square 0 holds two words, square 63 holds one word with one valid slot each -> moves in order (x,0),(y,0),(z,63), and sq_rden[0] pulses twice.
- mv_ready held low 5 cycles mid-word -> mv_from/mv_to stable for 5 cycles, with no loss or duplication.
- sq_done[30] never rises -> err_timeout=1 after 1023 WAIT_DONE cycles, list_done pulses, move_count=0.
- Reset low during UNPACK -> all outputs 0 next cycle. A new start then runs a clean pass with a correct move_count.
